rns2bin_32_31_21_5: RTL and testbench
=====================================

RNS2BIN_32_31_21_5 -- requirements
Module: rns2bin_32_31_21_5

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  residue tuple present.
- in_ready  out  1  tuple accepted on clk edge when in_valid=1.
- res_1  in  5  residue mod 32.
- res_2  in  5  residue mod 31.
- res_3  in  5  residue mod 21.
- res_4  in  3  residue mod 5.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- bin_out  out  17  binary value X, 0..104159.
- err  out  1  accepted tuple had an out-of-range residue.
REQ-002 SHALL have no parameters; the moduli set (32, 31, 21, 5) and M=104160 are fixed.

Function
REQ-003 SHALL compute X using sequential mixed-radix conversion: X = a1 + 32*a2 + 992*a3 + 20832*a4.
REQ-004 SHALL compute the digits as:
- a1 = res_1.
- a2 = (res_2 - a1) mod 31.
- a3 = ((res_3 - P2 mod 21)*17) mod 21, where P2 = a1 + 32*a2.
- a4 = ((res_4 - P3 mod 5)*3) mod 5, where P3 = P2 + 992*a3.
REQ-005 SHALL use the FSM states IDLE, DIG2, DIG3, DIG4, DONE.
REQ-006 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-007 SHALL accept a tuple on any edge with in_valid and in_ready both high:
- register the residues.
- P1 = res_1.
- go to DIG2.
REQ-008 SHALL perform one step per state, one cycle each:
- DIG2: register P2 (10 bits), go to DIG3.
- DIG3: register P3 (15 bits), go to DIG4.
- DIG4: register bin_out = P3 + 20832*a4 (17 bits), go to DONE.
REQ-009 SHALL drive out_valid = (state==DONE); out_valid is visible 4 cycles after the accepting edge.
REQ-010 SHALL hold bin_out and err stable while out_valid=1 and out_ready=0.
REQ-011 SHALL, in DONE with out_ready=1:
- go to IDLE when in_valid=0.
- accept the new tuple and go to DIG2 when in_valid=1 (back-to-back, no bubble).
REQ-012 SHALL, on acceptance of a tuple with res_2=31 or res_3>=21 or res_4>=5, go directly to DONE with bin_out=0 and err=1, skipping the DIG states.
REQ-013 SHALL clear err on every valid acceptance.
REQ-014 SHALL make every modular subtraction non-negative by adding the modulus before reduction.
REQ-015 SHALL ignore in_valid while in DIG2, DIG3 or DIG4 (in_ready=0).

Reset
REQ-016 SHALL, on reset, go asynchronously to state IDLE with bin_out=0, err=0, out_valid=0, in_ready=1 and all partial-sum registers at 0.
REQ-017 SHALL abandon any conversion in progress when reset is asserted, without producing an output.

Structure
REQ-018 SHALL place in the shared package rns_32_31_21_5_pkg:
- moduli 32, 31, 21, 5 and M=104160.
- residue widths 5/5/5/3 and output width 17.
- weights 32, 992, 20832.
- inverses 17 (mod 21) and 3 (mod 5).
- the FSM state enum.
REQ-019 SHALL implement the small-modulus reduction (mod 21 and mod 5 of a partial sum) in one sub-module rns_mod_reduce_small, instantiated per digit step.

Verification
REQ-020 SHALL cover: (0,0,0,0) -> bin_out=0, err=0, out_valid 4 cycles after acceptance.
REQ-021 SHALL cover: (25,7,18,0) -> bin_out=12345, with internal digits a2=13, a3=12, a4=0.
REQ-022 SHALL cover: (31,30,20,4) -> bin_out=104159 (maximum value, M-1).
REQ-023 SHALL cover: (3,31,0,0) -> out_valid one cycle after acceptance, bin_out=0, err=1; the following valid tuple clears err.
REQ-024 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable; then out_ready=1 with in_valid=1 -> next tuple accepted on the same edge.
REQ-025 SHALL cover: reset asserted during DIG3 -> IDLE immediately, out_valid never asserts for that tuple.

Source files
------------

// File: rtl/rns_32_31_21_5_pkg.sv
// Shared constants and types for the (32, 31, 21, 5) residue number system.
// Holds the moduli, the dynamic range M, the residue/output widths, the
// mixed-radix weights, the modular inverses used by the digit steps, and the
// state encoding of the residue-to-binary converter FSM.
package rns_32_31_21_5_pkg;

    // Moduli and dynamic range
    localparam int MOD_1 = 32;
    localparam int MOD_2 = 31;
    localparam int MOD_3 = 21;
    localparam int MOD_4 = 5;
    localparam int M     = 104160;

    // Residue and result widths
    localparam int RES1_W = 5;
    localparam int RES2_W = 5;
    localparam int RES3_W = 5;
    localparam int RES4_W = 3;
    localparam int OUT_W  = 17;

    // Mixed-radix weights: 32, 32*31, 32*31*21
    localparam int WEIGHT_2 = 32;
    localparam int WEIGHT_3 = 992;
    localparam int WEIGHT_4 = 20832;

    // Inverses: 992^-1 mod 21 = 17, 20832^-1 mod 5 = 3
    localparam int INV_3 = 17;
    localparam int INV_4 = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIG2 = 3'd1,
        DIG3 = 3'd2,
        DIG4 = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/rns_mod_reduce_small.sv
// Combinational reduction of an unsigned partial sum by a small constant
// modulus. One instance per reduction in each digit step.
// Ports:
//   value  in   DATA_W  unsigned operand
//   rem    out  OUT_W   value mod MODULUS
module rns_mod_reduce_small #(
    parameter int MODULUS = 21,
    parameter int DATA_W  = 10,
    parameter int OUT_W   = 5
) (
    input  logic [DATA_W-1:0] value,
    output logic [OUT_W-1:0]  rem
);

    localparam logic [DATA_W-1:0] MOD_D = DATA_W'(MODULUS);

    // Remainder always fits in OUT_W because it is below MODULUS.
    assign rem = OUT_W'(value % MOD_D);

endmodule

// File: rtl/rns2bin_32_31_21_5.sv
// Residue (32, 31, 21, 5) to binary converter using sequential mixed-radix
// conversion: X = a1 + 32*a2 + 992*a3 + 20832*a4, one digit per cycle.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid / in_ready     residue tuple handshake
//   res_1..res_4            residues mod 32, 31, 21, 5
//   out_valid / out_ready   result handshake
//   bin_out                 converted value 0..104159
//   err                     accepted tuple held an out-of-range residue
module rns2bin_32_31_21_5
    import rns_32_31_21_5_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  res_1,
    input  logic [4:0]  res_2,
    input  logic [4:0]  res_3,
    input  logic [2:0]  res_4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] bin_out,
    output logic        err
);

    state_t      state;
    logic [4:0]  r2;
    logic [4:0]  r3;
    logic [2:0]  r4;
    logic [4:0]  p1;
    logic [9:0]  p2;
    logic [14:0] p3;

    logic        accept;
    logic        bad;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // res_1 spans its full 5-bit range, so only the other three can be invalid.
    assign bad = (res_2 == 5'(MOD_2)) || (res_3 >= 5'(MOD_3)) || (res_4 >= 3'(MOD_4));

    // Digit 2: a2 = (res_2 - a1) mod 31. Adding 62 keeps the difference
    // non-negative even when a1 = 31 exceeds the modulus.
    logic [6:0] diff2;
    logic [4:0] a2;
    logic [9:0] p2_next;

    assign diff2 = 7'(r2) + 7'(2 * MOD_2) - 7'(p1);

    rns_mod_reduce_small #(.MODULUS(MOD_2), .DATA_W(7), .OUT_W(5)) u_red_a2 (
        .value (diff2),
        .rem   (a2)
    );

    assign p2_next = 10'(p1) + 10'(a2) * 10'(WEIGHT_2);

    // Digit 3: a3 = ((res_3 - P2 mod 21) * 17) mod 21
    logic [4:0] p2_m21;
    logic [5:0] diff3;
    logic [9:0] prod3;
    logic [4:0] a3;
    logic [14:0] p3_next;

    rns_mod_reduce_small #(.MODULUS(MOD_3), .DATA_W(10), .OUT_W(5)) u_red_p2 (
        .value (p2),
        .rem   (p2_m21)
    );

    assign diff3 = 6'(r3) + 6'(MOD_3) - 6'(p2_m21);
    assign prod3 = 10'(diff3) * 10'(INV_3);

    rns_mod_reduce_small #(.MODULUS(MOD_3), .DATA_W(10), .OUT_W(5)) u_red_a3 (
        .value (prod3),
        .rem   (a3)
    );

    assign p3_next = 15'(p2) + 15'(a3) * 15'(WEIGHT_3);

    // Digit 4: a4 = ((res_4 - P3 mod 5) * 3) mod 5
    logic [2:0]  p3_m5;
    logic [3:0]  diff4;
    logic [4:0]  prod4;
    logic [2:0]  a4;
    logic [16:0] bin_next;

    rns_mod_reduce_small #(.MODULUS(MOD_4), .DATA_W(15), .OUT_W(3)) u_red_p3 (
        .value (p3),
        .rem   (p3_m5)
    );

    assign diff4 = 4'(r4) + 4'(MOD_4) - 4'(p3_m5);
    assign prod4 = 5'(diff4) * 5'(INV_4);

    rns_mod_reduce_small #(.MODULUS(MOD_4), .DATA_W(5), .OUT_W(3)) u_red_a4 (
        .value (prod4),
        .rem   (a4)
    );

    assign bin_next = 17'(p3) + 17'(a4) * 17'(WEIGHT_4);

    // Control and datapath registers. Acceptance can only happen in IDLE or
    // in DONE with out_ready, so it takes priority over the per-state steps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            r2      <= '0;
            r3      <= '0;
            r4      <= '0;
            p1      <= '0;
            p2      <= '0;
            p3      <= '0;
            bin_out <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            r2 <= res_2;
            r3 <= res_3;
            r4 <= res_4;
            p1 <= res_1;
            if (bad) begin
                // Out-of-range tuple: report immediately, skip the digit steps.
                bin_out <= '0;
                err     <= 1'b1;
                state   <= DONE;
            end else begin
                err   <= 1'b0;
                state <= DIG2;
            end
        end else begin
            case (state)
                DIG2: begin
                    p2    <= p2_next;
                    state <= DIG3;
                end
                DIG3: begin
                    p3    <= p3_next;
                    state <= DIG4;
                end
                DIG4: begin
                    bin_out <= bin_next;
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rns2bin_32_31_21_5.sv
// Self-checking bench for rns2bin_32_31_21_5: a scoreboard queue holds the
// expected result, error flag and latency of every accepted tuple; a monitor
// pops and compares each new result and checks outputs stay stable while
// stalled.
module tb_rns2bin_32_31_21_5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  res_1 = '0;
    logic [4:0]  res_2 = '0;
    logic [4:0]  res_3 = '0;
    logic [2:0]  res_4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] bin_out;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int bin;
        int err;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rns2bin_32_31_21_5 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_1     (res_1),
        .res_2     (res_2),
        .res_3     (res_3),
        .res_4     (res_4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference by exhaustive search over the dynamic range.
    function automatic int model_x(input int r1, input int r2, input int r3, input int r4);
        for (int x = 0; x < rns_32_31_21_5_pkg::M; x++) begin
            if ((x % 32 == r1) && (x % 31 == r2) && (x % 21 == r3) && (x % 5 == r4))
                return x;
        end
        return -1;
    endfunction

    function automatic exp_t make_exp(input int b, input int e, input int l);
        exp_t t;
        t.bin = b;
        t.err = e;
        t.lat = l;
        t.acc = 0;
        return t;
    endfunction

    task automatic drive_tuple(input int r1, input int r2, input int r3, input int r4);
        res_1 = 5'(r1);
        res_2 = 5'(r2);
        res_3 = 5'(r3);
        res_4 = 3'(r4);
        in_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int r1, input int r2, input int r3, input int r4,
                        input int eb, input int ee, input int el);
        exp_t e;
        bit   got;
        got = 1'b0;
        drive_tuple(r1, r2, r3, r4);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
        end else begin
            e = make_exp(eb, ee, el);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_ok(input int r1, input int r2, input int r3, input int r4);
        send(r1, r2, r3, r4, model_x(r1, r2, r3, r4), 0, 4);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1 check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: a new result is out_valid after reset/idle or after a taken one.
    initial begin : monitor
        logic prev_ov;
        logic prev_taken;
        exp_t cur;
        prev_ov    = 1'b0;
        prev_taken = 1'b0;
        cur        = make_exp(0, 0, 0);
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ov    = 1'b0;
                prev_taken = 1'b0;
            end else begin
                if (out_valid && (!prev_ov || prev_taken)) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("bin_out", int'(bin_out), cur.bin);
                        check("err", int'(err), cur.err);
                        check("latency", cyc - cur.acc + 1, cur.lat);
                    end
                end else if (out_valid && prev_ov) begin
                    check("hold_bin", int'(bin_out), cur.bin);
                    check("hold_err", int'(err), cur.err);
                end
                prev_ov    = out_valid;
                prev_taken = out_valid && out_ready;
            end
        end
    end

    initial begin : driver
        int  r1, r2, r3, r4;
        bit  seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed vectors
        send(0, 0, 0, 0, 0, 0, 4);
        send(25, 7, 18, 0, 12345, 0, 4);
        send(31, 30, 20, 4, 104159, 0, 4);
        send(3, 31, 0, 0, 0, 1, 1);
        send(1, 1, 1, 1, 1, 0, 4);

        // Random valid tuples back to back, with a few invalid ones mixed in
        for (int i = 0; i < 8; i++) begin
            r1 = $urandom_range(0, 31);
            r2 = $urandom_range(0, 30);
            r3 = $urandom_range(0, 20);
            r4 = $urandom_range(0, 4);
            if (i == 2) send(r1, r2, $urandom_range(21, 31), r4, 0, 1, 1);
            else if (i == 5) send(r1, r2, r3, $urandom_range(5, 7), 0, 1, 1);
            else send_ok(r1, r2, r3, r4);
        end
        drain();

        // Consumer stall for 5 cycles, then release together with a new tuple
        @(posedge clk);
        #1 out_ready = 1'b0;
        send_ok(9, 20, 4, 2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_out_valid_seen", int'(seen), 1);
        repeat (5) @(posedge clk);
        #1;
        drive_tuple(14, 2, 11, 3);
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", int'(in_ready), 1);
        if (in_ready) begin
            sb.push_back(make_exp(model_x(14, 2, 11, 3), 0, 4));
            sb[sb.size() - 1].acc = cyc + 1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset asserted while the converter is in DIG3
        @(posedge clk);
        #1 drive_tuple(30, 29, 19, 3);
        @(negedge clk);
        check("rstmid_accept_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstmid_out_valid", int'(out_valid), 0);
        check("rstmid_in_ready", int'(in_ready), 1);
        check("rstmid_bin_out", int'(bin_out), 0);
        check("rstmid_err", int'(err), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Converter usable again after the abandoned conversion
        send_ok(7, 7, 7, 2);
        send(0, 0, 0, 0, 0, 0, 4);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
